regfile_write_arbiter: RTL and testbench

Shares the single write port of the 32x32 register file between the pipeline writeback stage and the multicycle multiply/divide unit (MDU), and keeps a 32-bit scoreboard of registers with an MDU result still outstanding. It sits between WB, the MDU and the register file write port, and supplies the decode stage with a stall on scoreboard hits. An optional starvation guard forces an MDU write by freezing WB for one cycle.

---
 rtl/regfile_write_arbiter.sv | 158 +++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_write_arbiter
//  Description : Shares the single register-file write port between the WB
//                stage and the multicycle MDU, and keeps a scoreboard of
//                registers that still have an MDU result outstanding. Decode
//                is stalled on any scoreboard hit.
//                Optional starvation guard: define REGARB_STARVE_GUARD_EN to
//                add the starve counter and the FORCE_MDU state. Without it,
//                WB has strict priority and wb_stall is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_write_reg,
    input  logic [31:0] wb_write_data,
    output logic        wb_stall,
    input  logic        mdu_issue,
    input  logic [4:0]  mdu_issue_reg,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_dest,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    output logic        id_stall,
    output logic        reg_write,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic [31:0] busy_mask
);

    // Reject out-of-range limits at elaboration time.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("regfile_write_arbiter: STARVE_LIMIT must be in 1..15");
    end

    logic        w_wb_valid;
    logic        w_wb_grant;
    logic        w_mdu_grant;
    logic        w_mdu_ready_raw;
    logic        w_wb_stall_raw;
    logic        w_wb_priority;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;
    logic [31:0] r_busy;

    // A WB write to r0 is dropped, so it never competes for the port.
    assign w_wb_valid = wb_reg_write && (wb_write_reg != 5'd0);

`ifdef REGARB_STARVE_GUARD_EN
    localparam logic [3:0] c_STARVE_LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        S_NORMAL    = 1'b0,
        S_FORCE_MDU = 1'b1
    } state_t;

    state_t     r_state;
    logic [3:0] r_starve_cnt;
    logic [3:0] w_starve_inc;
    logic       w_denied;

    assign w_denied     = mdu_valid && !mdu_ready;
    assign w_starve_inc = (r_starve_cnt == 4'hF) ? 4'hF : (r_starve_cnt + 4'd1);

    // Ownership of the port: WB wins in NORMAL, the MDU owns it in FORCE_MDU.
    always_comb begin
        w_wb_priority   = (r_state == S_NORMAL);
        w_mdu_ready_raw = (r_state == S_FORCE_MDU) ? 1'b1 : !w_wb_valid;
        w_wb_stall_raw  = (r_state == S_FORCE_MDU) && w_wb_valid;
    end

    // Starve counter and guard FSM; the forced grant lasts exactly one cycle
    // because FORCE_MDU always sees either a handshake or a dropped valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_NORMAL;
            r_starve_cnt <= 4'd0;
        end else begin
            r_starve_cnt <= w_denied ? w_starve_inc : 4'd0;
            case (r_state)
                S_NORMAL: begin
                    if (w_denied && (w_starve_inc >= c_STARVE_LIMIT))
                        r_state <= S_FORCE_MDU;
                end
                S_FORCE_MDU: begin
                    if (w_mdu_grant || !mdu_valid)
                        r_state <= S_NORMAL;
                end
                default: r_state <= S_NORMAL;
            endcase
        end
    end
`else
    // Strict WB priority: the MDU only gets the port when WB is idle.
    always_comb begin
        w_wb_priority   = 1'b1;
        w_mdu_ready_raw = !w_wb_valid;
        w_wb_stall_raw  = 1'b0;
    end
`endif

    // Handshake outputs are held low for the whole reset cycle.
    always_comb begin
        mdu_ready   = w_mdu_ready_raw && !reset;
        wb_stall    = w_wb_stall_raw && !reset;
        w_wb_grant  = w_wb_valid && w_wb_priority && !reset;
        w_mdu_grant = mdu_valid && mdu_ready;
    end

    // Write-port mux; an MDU result targeting r0 is accepted but not written.
    always_comb begin
        reg_write  = 1'b0;
        write_reg  = 5'd0;
        write_data = 32'd0;
        if (w_wb_grant) begin
            reg_write  = 1'b1;
            write_reg  = wb_write_reg;
            write_data = wb_write_data;
        end else if (w_mdu_grant) begin
            reg_write  = (mdu_dest != 5'd0);
            write_reg  = mdu_dest;
            write_data = mdu_data;
        end
    end

    // Scoreboard set/clear masks; only an unstalled issue allocates a register.
    always_comb begin
        w_set_mask = 32'd0;
        w_clr_mask = 32'd0;
        if (mdu_issue && !id_stall && (mdu_issue_reg != 5'd0))
            w_set_mask = 32'd1 << mdu_issue_reg;
        if (w_mdu_grant)
            w_clr_mask = 32'd1 << mdu_dest;
    end

    // Scoreboard update: set is applied after clear so it wins; r0 never busy.
    always_ff @(posedge clk) begin
        if (reset)
            r_busy <= 32'd0;
        else
            r_busy <= ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;
    end

    // Decode hazard detection on all three register fields.
    always_comb begin
        id_stall  = (r_busy[id_rs] || r_busy[id_rt] || r_busy[id_rd]) && !reset;
        busy_mask = reset ? 32'd0 : r_busy;
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_write_arbiter
//  Description : Self-checking bench for regfile_write_arbiter. Directed
//                scenarios plus randomized traffic, compared each cycle with
//                a behavioural model of the arbitration and scoreboard rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_reg_write;
    logic [4:0]  wb_write_reg;
    logic [31:0] wb_write_data;
    logic        wb_stall;
    logic        mdu_issue;
    logic [4:0]  mdu_issue_reg;
    logic        mdu_valid;
    logic [4:0]  mdu_dest;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_stall;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] busy_mask;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    bit m_busy [32];
    int m_starve;
    bit m_force;

    // Outputs sampled mid-cycle by run_cycle
    logic        s_wb_stall, s_mdu_ready, s_id_stall, s_reg_write;
    logic [4:0]  s_write_reg;
    logic [31:0] s_write_data, s_busy_mask;

    regfile_write_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk           (clk),
        .reset         (reset),
        .wb_reg_write  (wb_reg_write),
        .wb_write_reg  (wb_write_reg),
        .wb_write_data (wb_write_data),
        .wb_stall      (wb_stall),
        .mdu_issue     (mdu_issue),
        .mdu_issue_reg (mdu_issue_reg),
        .mdu_valid     (mdu_valid),
        .mdu_dest      (mdu_dest),
        .mdu_data      (mdu_data),
        .mdu_ready     (mdu_ready),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .id_stall      (id_stall),
        .reg_write     (reg_write),
        .write_reg     (write_reg),
        .write_data    (write_data),
        .busy_mask     (busy_mask)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        reset         = 1'b0;
        wb_reg_write  = 1'b0;
        wb_write_reg  = 5'd0;
        wb_write_data = 32'd0;
        mdu_issue     = 1'b0;
        mdu_issue_reg = 5'd0;
        mdu_valid     = 1'b0;
        mdu_dest      = 5'd0;
        mdu_data      = 32'd0;
        id_rs         = 5'd0;
        id_rt         = 5'd0;
        id_rd         = 5'd0;
    endtask

    // One clock cycle: inputs are already driven; compare against the model,
    // then advance the model across the rising edge.
    task automatic run_cycle();
        bit          wbv, wb_win, mdu_win, hs;
        logic        e_ready, e_wbst, e_regw, e_idst;
        logic [4:0]  e_reg;
        logic [31:0] e_data, e_mask;
        #1;
        s_wb_stall   = wb_stall;
        s_mdu_ready  = mdu_ready;
        s_id_stall   = id_stall;
        s_reg_write  = reg_write;
        s_write_reg  = write_reg;
        s_write_data = write_data;
        s_busy_mask  = busy_mask;

        wbv    = wb_reg_write && (wb_write_reg != 0);
        e_reg  = 5'd0;
        e_data = 32'd0;
        e_mask = 32'd0;
        if (reset) begin
            e_ready = 0; e_wbst = 0; e_regw = 0; e_idst = 0;
            wb_win  = 0; mdu_win = 0;
        end else begin
`ifdef REGARB_STARVE_GUARD_EN
            if (m_force) begin
                e_ready = 1; e_wbst = wbv; wb_win = 0;
            end else begin
                e_ready = !wbv; e_wbst = 0; wb_win = wbv;
            end
`else
            e_ready = !wbv; e_wbst = 0; wb_win = wbv;
`endif
            mdu_win = e_ready && mdu_valid;
            if (wb_win) begin
                e_regw = 1; e_reg = wb_write_reg; e_data = wb_write_data;
            end else if (mdu_win && mdu_dest != 0) begin
                e_regw = 1; e_reg = mdu_dest; e_data = mdu_data;
            end else begin
                e_regw = 0;
            end
            e_idst = m_busy[id_rs] || m_busy[id_rt] || m_busy[id_rd];
            for (int i = 0; i < 32; i++)
                if (m_busy[i]) e_mask = e_mask + (32'd1 << i);
        end

        check("reg_write", s_reg_write, e_regw);
        check("wb_stall",  s_wb_stall,  e_wbst);
        check("mdu_ready", s_mdu_ready, e_ready);
        check("id_stall",  s_id_stall,  e_idst);
        check("busy_mask", s_busy_mask, e_mask);
        if (e_regw) begin
            check("write_reg",  s_write_reg,  e_reg);
            check("write_data", s_write_data, e_data);
        end

        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
            m_starve = 0;
            m_force  = 0;
        end else begin
            hs = mdu_valid && e_ready;
            if (hs) m_busy[mdu_dest] = 0;
            if (mdu_issue && !e_idst && mdu_issue_reg != 0) m_busy[mdu_issue_reg] = 1;
            m_busy[0] = 0;
            if (mdu_valid && !e_ready) m_starve = (m_starve < 15) ? m_starve + 1 : 15;
            else                       m_starve = 0;
            if (m_force)                        m_force = 0;
            else if (m_starve >= STARVE_LIMIT)  m_force = 1;
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
        m_starve = 0;
        m_force  = 0;
        idle_inputs();

        // Reset with every input active
        reset = 1; wb_reg_write = 1; wb_write_reg = 5'd3; wb_write_data = 32'hDEAD_BEEF;
        mdu_issue = 1; mdu_issue_reg = 5'd5; mdu_valid = 1; mdu_dest = 5'd6; mdu_data = 32'h55;
        id_rs = 5'd5; id_rt = 5'd6; id_rd = 5'd7;
        for (int c = 0; c < 2; c++) begin
            run_cycle();
            check("rst_reg_write", s_reg_write, 0);
            check("rst_mdu_ready", s_mdu_ready, 0);
            check("rst_id_stall",  s_id_stall,  0);
            check("rst_busy_mask", s_busy_mask, 0);
        end
        idle_inputs();
        run_cycle();
        check("post_rst_busy", s_busy_mask, 0);

        // Issue to r5, then hazard, then MDU writeback clears it
        mdu_issue = 1; mdu_issue_reg = 5'd5;
        run_cycle();
        idle_inputs(); id_rs = 5'd5;
        run_cycle();
        check("raw_stall", s_id_stall, 1);
        idle_inputs(); mdu_valid = 1; mdu_dest = 5'd5; mdu_data = 32'h1234;
        run_cycle();
        check("mdu_wr_en",   s_reg_write,  1);
        check("mdu_wr_reg",  s_write_reg,  5);
        check("mdu_wr_data", s_write_data, 32'h1234);
        idle_inputs(); id_rs = 5'd5;
        run_cycle();
        check("clr_stall", s_id_stall, 0);
        check("clr_busy5", s_busy_mask[5], 0);

        // WB to r3 beats the MDU; WB to r0 frees the port
        idle_inputs(); wb_reg_write = 1; wb_write_reg = 5'd3; wb_write_data = 32'hA5A5_0003;
        mdu_valid = 1; mdu_dest = 5'd6; mdu_data = 32'h0000_0666;
        run_cycle();
        check("wb_win_reg",   s_write_reg, 3);
        check("wb_win_ready", s_mdu_ready, 0);
        wb_write_reg = 5'd0;
        run_cycle();
        check("r0_drop_ready", s_mdu_ready, 1);
        check("r0_drop_wr",    s_reg_write, 1);
        check("r0_drop_reg",   s_write_reg, 6);

        // Starvation: WB writes r7 every cycle while the MDU waits
        idle_inputs(); wb_reg_write = 1; wb_write_reg = 5'd7; wb_write_data = 32'h7777;
        mdu_valid = 1; mdu_dest = 5'd8; mdu_data = 32'h8888;
        for (int c = 0; c < STARVE_LIMIT; c++) begin
            run_cycle();
            check("starve_denied", s_mdu_ready, 0);
        end
        run_cycle();
`ifdef REGARB_STARVE_GUARD_EN
        check("force_ready", s_mdu_ready, 1);
        check("force_stall", s_wb_stall,  1);
        check("force_reg",   s_write_reg, 8);
`else
        check("noguard_ready", s_mdu_ready, 0);
        check("noguard_stall", s_wb_stall,  0);
        check("noguard_reg",   s_write_reg, 7);
`endif
        run_cycle();
        check("wb_resume_reg",   s_write_reg, 7);
        check("wb_resume_stall", s_wb_stall,  0);

        // Same-cycle clear and set on r9: set wins
        idle_inputs(); mdu_issue = 1; mdu_issue_reg = 5'd9;
        run_cycle();
        idle_inputs(); mdu_issue = 1; mdu_issue_reg = 5'd9;
        mdu_valid = 1; mdu_dest = 5'd9; mdu_data = 32'h99;
        run_cycle();
        idle_inputs();
        run_cycle();
        check("set_wins_busy9", s_busy_mask[9], 1);

        // Reset arriving while the guard would be forcing the MDU
        idle_inputs(); wb_reg_write = 1; wb_write_reg = 5'd7; wb_write_data = 32'h7;
        mdu_valid = 1; mdu_dest = 5'd10; mdu_data = 32'hA;
        for (int c = 0; c < STARVE_LIMIT; c++) run_cycle();
        reset = 1;
        run_cycle();
        check("rst_force_stall", s_wb_stall, 0);
        reset = 0;
        run_cycle();
        check("after_rst_stall", s_wb_stall,  0);
        check("after_rst_ready", s_mdu_ready, 0);
        check("after_rst_busy",  s_busy_mask, 0);

        // Randomized traffic over a narrow register range to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 99) == 0);
            wb_reg_write  = $urandom_range(0, 1) == 1;
            wb_write_reg  = 5'($urandom_range(0, 7));
            wb_write_data = $urandom;
            mdu_issue     = ($urandom_range(0, 3) == 0);
            mdu_issue_reg = 5'($urandom_range(0, 7));
            mdu_valid     = ($urandom_range(0, 4) < 3);
            mdu_dest      = 5'($urandom_range(0, 7));
            mdu_data      = $urandom;
            id_rs         = 5'($urandom_range(0, 7));
            id_rt         = 5'($urandom_range(0, 7));
            id_rd         = 5'($urandom_range(0, 31));
            run_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
